ccff_loader: RTL

- Drives the fabric configuration chain from the host side. Generates prog_clk and ccff_head, and accepts ccff_tail.
- Takes a byte stream over a valid/ready handshake and serialises it MSB-first into a shift chain of CHAIN_LEN flops.
- Runs in the clk domain of the harness, next to the fabric's config port. Optionally verifies the loaded chain by loop-back readback with CRC.

---
 rtl/ccff_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ccff_loader.sv
// Host-side loader for the fabric configuration chain: serialises a byte stream MSB-first
// onto ccff_head with a divided prog_clk. Define CCFF_READBACK_EN for loop-back CRC verify.
module ccff_loader #(
  parameter int CHAIN_LEN = 128,
  parameter int DIV       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       prog_clk,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       crc_err
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, SETUP, HIGH, FIN, VSETUP, VHIGH
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div_cnt, div_n;
  logic [CW-1:0]   bit_cnt, bit_n, bit_inc;
  logic [7:0]      shreg, shreg_n;
  logic            head_n;
  logic            phase_end;

`ifdef CCFF_READBACK_EN
  logic [7:0] crc_load, crc_load_n;
  logic [7:0] crc_rb, crc_rb_n;
  logic       crc_err_q, crc_err_n;

  // CRC-8, poly 0x07, MSB-first, one bit per call.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction
`endif

  assign phase_end = (div_cnt == DW'(DIV - 1));
  assign bit_inc   = bit_cnt + CW'(1);

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_n = state;
    div_n   = '0;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    head_n  = ccff_head;
`ifdef CCFF_READBACK_EN
    crc_load_n = crc_load;
    crc_rb_n   = crc_rb;
    crc_err_n  = crc_err_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          bit_n   = '0;
`ifdef CCFF_READBACK_EN
          crc_load_n = '0;
          crc_rb_n   = '0;
          crc_err_n  = 1'b0;
`endif
        end
      end
      FETCH: begin
        if (s_valid && s_ready) begin
          shreg_n = s_data;
          head_n  = s_data[7];
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (phase_end) state_n = HIGH;
        else           div_n   = div_cnt + DW'(1);
      end
      HIGH: begin
        if (!phase_end) begin
          div_n = div_cnt + DW'(1);
        end else begin
          shreg_n = {shreg[6:0], 1'b0};
          bit_n   = bit_inc;
`ifdef CCFF_READBACK_EN
          crc_load_n = crc8_step(crc_load, shreg[7]);
`endif
          if (bit_inc == CW'(CHAIN_LEN)) begin
`ifdef CCFF_READBACK_EN
            // Feed the chain's own output back in: CHAIN_LEN edges rotate it back to where it was.
            state_n  = VSETUP;
            bit_n    = '0;
            head_n   = ccff_tail;
            crc_rb_n = crc8_step(crc_rb, ccff_tail);
`else
            state_n = FIN;
            head_n  = 1'b0;
`endif
          end else if ((32'(bit_inc) % 8) == 0) begin
            state_n = FETCH;
          end else begin
            state_n = SETUP;
            head_n  = shreg[6];
          end
        end
      end
`ifdef CCFF_READBACK_EN
      VSETUP: begin
        if (phase_end) state_n = VHIGH;
        else           div_n   = div_cnt + DW'(1);
      end
      VHIGH: begin
        if (!phase_end) begin
          div_n = div_cnt + DW'(1);
        end else begin
          bit_n = bit_inc;
          if (bit_inc == CW'(CHAIN_LEN)) begin
            state_n   = FIN;
            head_n    = 1'b0;
            crc_err_n = (crc_load != crc_rb);
          end else begin
            state_n  = VSETUP;
            head_n   = ccff_tail;
            crc_rb_n = crc8_step(crc_rb, ccff_tail);
          end
        end
      end
`endif
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      s_ready   <= 1'b0;
      prog_clk  <= 1'b0;
      ccff_head <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      // Outputs are decoded from the next state so they line up with it, glitch-free.
      s_ready   <= (state_n == FETCH);
      prog_clk  <= (state_n inside {HIGH, VHIGH});
      ccff_head <= head_n;
      busy      <= (state_n inside {FETCH, SETUP, HIGH, VSETUP, VHIGH});
      done      <= (state_n == FIN);
    end
  end

`ifdef CCFF_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_load  <= '0;
      crc_rb    <= '0;
      crc_err_q <= 1'b0;
    end else begin
      crc_load  <= crc_load_n;
      crc_rb    <= crc_rb_n;
      crc_err_q <= crc_err_n;
    end
  end

  assign crc_err = crc_err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign crc_err     = 1'b0;
`endif

endmodule
